// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller between the CPU memory stage and a word RAM.
// Handles request/response handshake, programmable wait states, sub-word access and fault reporting.
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              req_ready,
    input  logic              we,
    input  logic [2:0]        dm_ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LatCount = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;

    logic              reqWe_q;
    logic [2:0]        reqCtrl_q;
    logic [ADDR_W-1:0] reqAddr_q;
    logic [31:0]       reqWdata_q;

    logic              respValid_q;
    logic [31:0]       respRdata_q;
    logic              respErr_q;

    logic              accept;
    logic              enterResp;

    logic              opWe;
    logic [2:0]        opCtrl;
    logic [ADDR_W-1:0] opAddr;
    logic [31:0]       opWdata;

    logic [ADDR_W-1:0] upperAddr;
    logic [IdxW-1:0]   wordIdx;
    logic [1:0]        offset;
    logic              illegal;
    logic              misaligned;
    logic              outOfRange;
    logic              accessErr;

    logic [3:0]        byteEn;
    logic [31:0]       storeData;
    logic              memWrite;
    logic [31:0]       memWord;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic [31:0]       loadData;

    logic [31:0]       mem [DEPTH_WORDS];

    assign req_ready  = !rst && (state_q != WAIT);
    assign accept     = req && req_ready;
    assign resp_valid = respValid_q;
    assign resp_rdata = respRdata_q;
    assign resp_err   = respErr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        count_d = LatCount;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (count_q <= 4'd1) begin
                    state_d = RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enterResp = !rst && (state_d == RESP);

    always_ff @(posedge clk) begin
        if (accept) begin
            reqWe_q    <= we;
            reqCtrl_q  <= dm_ctrl;
            reqAddr_q  <= addr;
            reqWdata_q <= wdata;
        end
    end

    // With zero wait states the access completes on the accept edge, so it must use the live inputs.
    always_comb begin
        if (LATENCY == 0) begin
            opWe    = we;
            opCtrl  = dm_ctrl;
            opAddr  = addr;
            opWdata = wdata;
        end else begin
            opWe    = reqWe_q;
            opCtrl  = reqCtrl_q;
            opAddr  = reqAddr_q;
            opWdata = reqWdata_q;
        end
    end

    always_comb begin
        upperAddr  = opAddr >> (IdxW + 2);
        wordIdx    = opAddr[IdxW+1:2];
        offset     = opAddr[1:0];
        illegal    = (opCtrl == 3'b011) || (opCtrl[2:1] == 2'b11) || (opWe && opCtrl[2]);
        misaligned = ((opCtrl[1:0] == 2'b01) && offset[0])
                  || ((opCtrl[1:0] == 2'b10) && (offset != 2'b00));
        outOfRange = |upperAddr;
        accessErr  = illegal || misaligned || outOfRange;
    end

    always_comb begin
        byteEn    = 4'b1111;
        storeData = opWdata;
        case (opCtrl[1:0])
            2'b00: begin
                byteEn    = 4'b0001 << offset;
                storeData = {4{opWdata[7:0]}};
            end
            2'b01: begin
                byteEn    = offset[1] ? 4'b1100 : 4'b0011;
                storeData = {2{opWdata[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = opWdata;
            end
        endcase
        memWrite = enterResp && opWe && !accessErr;
    end

    // RAM has no reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        memWord  = mem[wordIdx];
        loadByte = memWord[{offset, 3'b000} +: 8];
        loadHalf = offset[1] ? memWord[31:16] : memWord[15:0];
        case (opCtrl)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b010:  loadData = memWord;
            3'b100:  loadData = {24'd0, loadByte};
            3'b101:  loadData = {16'd0, loadHalf};
            default: loadData = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
        end else if (enterResp) begin
            respValid_q <= 1'b1;
            respErr_q   <= accessErr;
            respRdata_q <= (accessErr || opWe) ? 32'd0 : loadData;
        end else begin
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: three instances with LATENCY 2, 0 and 5 share
// the stimulus bus, and `sel` picks which one sees req and which one drives the observed outputs.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  dmCtrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;

    logic [2:0]  readyV;
    logic [2:0]  validV;
    logic [2:0]  errV;
    logic [31:0] rdataV [3];

    logic        reqReady;
    logic        respValid;
    logic        respErr;
    logic [31:0] respRdata;

    int checks;
    int errors;

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(128), .LATENCY(2)) uLat2 (
        .clk(clk), .rst(rst), .req(req && (sel == 0)), .req_ready(readyV[0]),
        .we(we), .dm_ctrl(dmCtrl), .addr(addr), .wdata(wdata),
        .resp_valid(validV[0]), .resp_rdata(rdataV[0]), .resp_err(errV[0])
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(128), .LATENCY(0)) uLat0 (
        .clk(clk), .rst(rst), .req(req && (sel == 1)), .req_ready(readyV[1]),
        .we(we), .dm_ctrl(dmCtrl), .addr(addr), .wdata(wdata),
        .resp_valid(validV[1]), .resp_rdata(rdataV[1]), .resp_err(errV[1])
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(128), .LATENCY(5)) uLat5 (
        .clk(clk), .rst(rst), .req(req && (sel == 2)), .req_ready(readyV[2]),
        .we(we), .dm_ctrl(dmCtrl), .addr(addr), .wdata(wdata),
        .resp_valid(validV[2]), .resp_rdata(rdataV[2]), .resp_err(errV[2])
    );

    always_comb begin
        reqReady  = readyV[sel];
        respValid = validV[sel];
        respErr   = errV[sel];
        respRdata = rdataV[sel];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one request and returns just after the accept edge with the bus scrambled,
    // so any late sampling of the inputs corrupts the result.
    task automatic applyStimulus(input logic w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        int guard = 0;
        @(negedge clk);
        we = w;
        dmCtrl = c;
        addr = a;
        wdata = d;
        req = 1'b1;
        while (!reqReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        we = ~w;
        dmCtrl = 3'b111;
        addr = ~a;
        wdata = ~d;
    endtask

    task automatic collectResponse(output int cycles, output logic [31:0] rdata, output logic err);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!respValid && cycles < 20);
        rdata = respRdata;
        err = respErr;
    endtask

    task automatic doAccess(input string tag, input logic w, input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] expRdata, input logic expErr,
                            input int expLat);
        int lat;
        logic [31:0] rd;
        logic e;
        applyStimulus(w, c, a, d);
        collectResponse(lat, rd, e);
        checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".rdata"}, rd, expRdata);
        checkOutput({tag, ".err"}, {31'd0, e}, {31'd0, expErr});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        sel = 0;
        rst = 1'b1;
        req = 1'b0;
        we = 1'b0;
        dmCtrl = 3'b000;
        addr = '0;
        wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("reset.ready", {31'd0, reqReady}, 32'd0);
            checkOutput("reset.valid", {31'd0, respValid}, 32'd0);
            checkOutput("reset.rdata", respRdata, 32'd0);
            checkOutput("reset.err", {31'd0, respErr}, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("reset.readyAfter", {31'd0, reqReady}, 32'd1);
        end

        $display("[TB] LATENCY=2 word, sub-word and error accesses");
        sel = 0;
        doAccess("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        @(negedge clk);
        checkOutput("sw10.pulse", {31'd0, respValid}, 32'd0);
        doAccess("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        doAccess("sb13", 1'b1, 3'b000, 32'h13, 32'hABCDEF80, 32'h0, 1'b0, 3);
        doAccess("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        doAccess("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 3);
        doAccess("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 3);
        doAccess("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 3);
        doAccess("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);

        doAccess("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 3);
        doAccess("sh13", 1'b1, 3'b001, 32'h13, 32'h00005555, 32'h0, 1'b1, 3);
        doAccess("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);
        doAccess("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1, 3);
        doAccess("sw1fc", 1'b1, 3'b010, 32'h1FC, 32'h11223344, 32'h0, 1'b0, 3);
        doAccess("lw1fc", 1'b0, 3'b010, 32'h1FC, 32'h0, 32'h11223344, 1'b0, 3);
        doAccess("ctrl111", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 3);
        doAccess("ctrl011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 3);
        doAccess("sbu10", 1'b1, 3'b100, 32'h10, 32'h000000FF, 32'h0, 1'b1, 3);
        doAccess("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);
        doAccess("sh16", 1'b1, 3'b001, 32'h16, 32'h00008765, 32'h0, 1'b0, 3);
        doAccess("lh16", 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8765, 1'b0, 3);

        $display("[TB] LATENCY=2 handshake hold-off");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        checkOutput("hold.readyWait", {31'd0, reqReady}, 32'd0);
        checkOutput("hold.valid1", {31'd0, respValid}, 32'd0);
        req = 1'b1;
        we = 1'b1;
        dmCtrl = 3'b010;
        addr = 32'h14;
        wdata = 32'h0;
        @(negedge clk);
        req = 1'b0;
        checkOutput("hold.valid2", {31'd0, respValid}, 32'd0);
        @(negedge clk);
        checkOutput("hold.valid3", {31'd0, respValid}, 32'd1);
        checkOutput("hold.rdata", respRdata, 32'h80ADBEEF);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (respValid) seen++;
        end
        checkOutput("hold.extraResp", 32'(seen), 32'd0);
        doAccess("hold.lhu16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h00008765, 1'b0, 3);

        $display("[TB] LATENCY=0 back-to-back loads");
        sel = 1;
        doAccess("b2b.sw0", 1'b1, 3'b010, 32'h0, 32'h11111111, 32'h0, 1'b0, 1);
        doAccess("b2b.sw4", 1'b1, 3'b010, 32'h4, 32'h22222222, 32'h0, 1'b0, 1);
        doAccess("b2b.sw8", 1'b1, 3'b010, 32'h8, 32'h33333333, 32'h0, 1'b0, 1);
        doAccess("b2b.swc", 1'b1, 3'b010, 32'hC, 32'h44444444, 32'h0, 1'b0, 1);
        @(negedge clk);
        req = 1'b1;
        we = 1'b0;
        dmCtrl = 3'b010;
        addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) addr = 32'((i + 1) * 4);
            else req = 1'b0;
            @(negedge clk);
            checkOutput("b2b.valid", {31'd0, respValid}, 32'd1);
            checkOutput("b2b.ready", {31'd0, reqReady}, 32'd1);
            checkOutput("b2b.rdata", respRdata, 32'h11111111 * 32'(i + 1));
        end
        @(negedge clk);
        checkOutput("b2b.validEnd", {31'd0, respValid}, 32'd0);

        $display("[TB] LATENCY=5 reset during WAIT");
        sel = 2;
        doAccess("rst.sw20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 6);
        applyStimulus(1'b1, 3'b010, 32'h20, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst.ready", {31'd0, reqReady}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst.validDuring", {31'd0, respValid}, 32'd0);
            checkOutput("rst.readyDuring", {31'd0, reqReady}, 32'd0);
        end
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (respValid) seen++;
        end
        checkOutput("rst.noResp", 32'(seen), 32'd0);
        doAccess("rst.lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
